// File: rtl/arm_m0_alu_pkg.sv
// Shared definitions for the sequential Cortex-M0 ALU: opcodes and FSM states.
package arm_m0_alu_pkg;

    localparam logic [2:0] ALU_AND    = 3'b000;
    localparam logic [2:0] ALU_EOR    = 3'b001;
    localparam logic [2:0] ALU_SUB    = 3'b010;
    localparam logic [2:0] ALU_ADD    = 3'b011;
    localparam logic [2:0] ALU_ORR    = 3'b100;
    localparam logic [2:0] ALU_BIC    = 3'b101;
    localparam logic [2:0] ALU_MUL    = 3'b110;
    localparam logic [2:0] ALU_PASS_B = 3'b111;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        DONE     = 2'd2
    } alu_state_e;

endpackage

// File: rtl/arm_m0_iter_mul.sv
// Iterative shift-add multiplier producing the low WIDTH bits of A*B.
// The parent FSM pulses start_i on acceptance and holds step_i while busy;
// done_o flags the final step, with product_o carrying the finished value.
module arm_m0_iter_mul
    import arm_m0_alu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int EARLY_TERM = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] mcand_i,
    input  logic [WIDTH-1:0] mplier_i,
    output logic             done_o,
    output logic [WIDTH-1:0] product_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CW-1:0]    count_q, count_d;
    logic             lastStep;

    // One multiply step: conditionally add, shift both operands, and decide whether this is the last step.
    always_comb begin
        acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + 1'b1;
        lastStep = (count_q == LAST_COUNT) || ((EARLY_TERM != 0) && (mplier_d == '0));
        done_o    = step_i && lastStep;
        product_o = acc_d;
    end

    // Load operands on start, advance one bit per busy cycle otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
        end else if (start_i) begin
            acc_q    <= '0;
            mcand_q  <= mcand_i;
            mplier_q <= mplier_i;
            count_q  <= '0;
        end else if (step_i) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/arm_cortex_m0_seq_alu.sv
// Handshaked Cortex-M0 ALU with registered result and NZCV flags.
// Single-cycle ops complete at the accepting edge; MUL runs in the iterative multiplier.
module arm_cortex_m0_seq_alu
    import arm_m0_alu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int EARLY_TERM = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand_A,
    input  logic [WIDTH-1:0] operand_B,
    input  logic [2:0]       alu_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             neg,
    output logic             zero,
    output logic             carry,
    output logic             overflow
);

    localparam int MSB = WIDTH - 1;

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             overflow_q, overflow_d;

    logic             isSub;
    logic [WIDTH-1:0] addB;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] aluResult;
    logic             aluCarry;
    logic             aluOverflow;

    logic             mulStart;
    logic             mulStep;
    logic             mulDone;
    logic [WIDTH-1:0] mulProduct;

    assign mulStart = (state_q == IDLE) && in_valid && (alu_control == ALU_MUL);
    assign mulStep  = (state_q == MUL_BUSY);

    arm_m0_iter_mul #(
        .WIDTH      (WIDTH),
        .EARLY_TERM (EARLY_TERM)
    ) u_mul (
        .clk       (clk),
        .reset     (reset),
        .start_i   (mulStart),
        .step_i    (mulStep),
        .mcand_i   (operand_A),
        .mplier_i  (operand_B),
        .done_o    (mulDone),
        .product_o (mulProduct)
    );

    // Single-cycle datapath: one WIDTH+1 adder serves ADD and SUB (A + ~B + 1), its top bit is the carry.
    always_comb begin
        isSub       = (alu_control == ALU_SUB);
        addB        = isSub ? ~operand_B : operand_B;
        sum         = {1'b0, operand_A} + {1'b0, addB} + {{WIDTH{1'b0}}, isSub};
        aluResult   = '0;
        aluCarry    = 1'b0;
        aluOverflow = 1'b0;
        case (alu_control)
            ALU_AND:    aluResult = operand_A & operand_B;
            ALU_EOR:    aluResult = operand_A ^ operand_B;
            ALU_ORR:    aluResult = operand_A | operand_B;
            ALU_BIC:    aluResult = operand_A & ~operand_B;
            ALU_PASS_B: aluResult = operand_B;
            ALU_ADD: begin
                aluResult   = sum[WIDTH-1:0];
                aluCarry    = sum[WIDTH];
                aluOverflow = (operand_A[MSB] == operand_B[MSB]) && (sum[MSB] != operand_A[MSB]);
            end
            ALU_SUB: begin
                aluResult   = sum[WIDTH-1:0];
                aluCarry    = sum[WIDTH];
                aluOverflow = (operand_A[MSB] != operand_B[MSB]) && (sum[MSB] != operand_A[MSB]);
            end
            default: aluResult = '0;
        endcase
    end

    // Next-state and result capture: accept in IDLE, wait for the multiplier, hold in DONE until consumed.
    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        carry_d    = carry_q;
        overflow_d = overflow_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (alu_control == ALU_MUL) begin
                        state_d = MUL_BUSY;
                    end else begin
                        result_d   = aluResult;
                        carry_d    = aluCarry;
                        overflow_d = aluOverflow;
                        state_d    = DONE;
                    end
                end
            end
            MUL_BUSY: begin
                if (mulDone) begin
                    result_d   = mulProduct;
                    carry_d    = 1'b0;
                    overflow_d = 1'b0;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and result registers; reset aborts any multiply in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            result_q   <= '0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            result_q   <= result_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign neg       = result_q[MSB];
    assign zero      = (result_q == '0);
    assign carry     = carry_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_arm_cortex_m0_seq_alu.sv
// Directed testbench: one DUT with EARLY_TERM=0, one with EARLY_TERM=1, sharing clock and operands.
module tb_arm_cortex_m0_seq_alu;
    import arm_m0_alu_pkg::*;

    logic        clk;
    logic        reset;
    logic        inValid0, inValid1;
    logic [31:0] operandA, operandB;
    logic [2:0]  aluControl;
    logic        outReady;

    logic        inReady0, outValid0, neg0, zero0, carry0, overflow0;
    logic [31:0] result0;
    logic        inReady1, outValid1, neg1, zero1, carry1, overflow1;
    logic [31:0] result1;

    logic        curSel;
    logic        selInReady, selOutValid;
    logic [31:0] selResult;
    logic [3:0]  selNzcv;

    int checkCount;
    int passCount;

    arm_cortex_m0_seq_alu #(.WIDTH(32), .EARLY_TERM(0)) dut0 (
        .clk(clk), .reset(reset), .in_valid(inValid0), .in_ready(inReady0),
        .operand_A(operandA), .operand_B(operandB), .alu_control(aluControl),
        .out_valid(outValid0), .out_ready(outReady), .result(result0),
        .neg(neg0), .zero(zero0), .carry(carry0), .overflow(overflow0)
    );

    arm_cortex_m0_seq_alu #(.WIDTH(32), .EARLY_TERM(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(inValid1), .in_ready(inReady1),
        .operand_A(operandA), .operand_B(operandB), .alu_control(aluControl),
        .out_valid(outValid1), .out_ready(outReady), .result(result1),
        .neg(neg1), .zero(zero1), .carry(carry1), .overflow(overflow1)
    );

    assign selInReady  = curSel ? inReady1  : inReady0;
    assign selOutValid = curSel ? outValid1 : outValid0;
    assign selResult   = curSel ? result1   : result0;
    assign selNzcv     = curSel ? {neg1, zero1, carry1, overflow1} : {neg0, zero0, carry0, overflow0};

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count one comparison and report it if observed differs from expected.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Present an op to the selected DUT and hold it for exactly the accepting edge.
    task automatic applyStimulus(input logic sel, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
        curSel = sel;
        @(negedge clk);
        checkOutput({tag, " inReady before issue"}, 64'(selInReady), 64'd1);
        operandA   = a;
        operandB   = b;
        aluControl = op;
        if (sel) inValid1 = 1'b1;
        else     inValid0 = 1'b1;
        @(posedge clk);
        #1;
        inValid0 = 1'b0;
        inValid1 = 1'b0;
        operandA = 32'hDEAD_BEEF;
        operandB = 32'h1234_5678;
    endtask

    // Wait (bounded) for out_valid, then check latency, result, flags and that in_ready stayed low.
    task automatic awaitResult(input logic [31:0] expRes, input logic [3:0] expNzcv, input int expLat, input string tag);
        int  lat;
        logic readySeen;
        lat = 1;
        readySeen = 1'b0;
        @(negedge clk);
        while (!selOutValid && lat < 200) begin
            if (selInReady) readySeen = 1'b1;
            @(negedge clk);
            lat++;
        end
        if (selInReady) readySeen = 1'b1;
        checkOutput({tag, " latency"}, 64'(lat), 64'(expLat));
        checkOutput({tag, " result"}, 64'(selResult), 64'(expRes));
        checkOutput({tag, " nzcv"}, 64'(selNzcv), 64'(expNzcv));
        checkOutput({tag, " inReady while busy"}, 64'(readySeen), 64'd0);
    endtask

    // Let writeback take the result for one edge.
    task automatic consume();
        outReady = 1'b1;
        @(posedge clk);
        #1;
        outReady = 1'b0;
    endtask

    task automatic runOp(input logic sel, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expRes, input logic [3:0] expNzcv, input int expLat, input string tag);
        applyStimulus(sel, op, a, b, tag);
        awaitResult(expRes, expNzcv, expLat, tag);
        consume();
    endtask

    // Main directed sequence.
    initial begin
        checkCount = 0;
        passCount  = 0;
        curSel     = 1'b0;
        inValid0   = 1'b0;
        inValid1   = 1'b0;
        operandA   = '0;
        operandB   = '0;
        aluControl = ALU_AND;
        outReady   = 1'b0;
        reset      = 1'b1;

        #2;
        checkOutput("reset outValid", 64'(outValid0), 64'd0);
        checkOutput("reset inReady", 64'(inReady0), 64'd1);
        checkOutput("reset result", 64'(result0), 64'd0);
        checkOutput("reset nzcv", 64'({neg0, zero0, carry0, overflow0}), 64'b0100);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Single-cycle ops, nzcv order is {N,Z,C,V}
        runOp(0, ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b1001, 1, "ADD ovf");
        runOp(0, ALU_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0110, 1, "ADD carry");
        runOp(0, ALU_SUB, 32'd5,         32'd5,         32'h0000_0000, 4'b0110, 1, "SUB equal");
        runOp(0, ALU_SUB, 32'd0,         32'd1,         32'hFFFF_FFFF, 4'b1000, 1, "SUB borrow");
        runOp(0, ALU_SUB, 32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 4'b0011, 1, "SUB ovf");
        runOp(0, ALU_AND, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 4'b0000, 1, "AND");
        runOp(0, ALU_EOR, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 4'b0000, 1, "EOR");
        runOp(0, ALU_ORR, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 4'b0000, 1, "ORR");
        runOp(0, ALU_PASS_B, 32'h1111_1111, 32'h8000_0001, 32'h8000_0001, 4'b1000, 1, "PASS_B");

        // Full-length multiplies
        runOp(0, ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 4'b0000, 33, "MUL full ones");
        runOp(0, ALU_MUL, 32'd1234, 32'd3, 32'd3702, 4'b0000, 33, "MUL no early");

        // Early-terminating multiplies
        runOp(1, ALU_MUL, 32'd1234, 32'd3, 32'd3702, 4'b0000, 3, "MUL early");
        runOp(1, ALU_MUL, 32'd1234, 32'd0, 32'd0, 4'b0100, 2, "MUL early B0");
        runOp(1, ALU_MUL, 32'h0001_0000, 32'h0001_0000, 32'd0, 4'b0100, 18, "MUL early wrap");
        runOp(1, ALU_MUL, 32'd7, 32'h8000_0000, 32'h8000_0000, 4'b1000, 33, "MUL early msb");

        // Backpressure on a BIC result; a second op offered meanwhile must be ignored
        applyStimulus(0, ALU_BIC, 32'h0000_00FF, 32'h0000_000F, "BIC");
        awaitResult(32'h0000_00F0, 4'b0000, 1, "BIC");
        operandA   = 32'd1;
        operandB   = 32'd1;
        aluControl = ALU_ADD;
        inValid0   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("BIC held result", 64'(result0), 64'h0000_00F0);
            checkOutput("BIC held outValid", 64'(outValid0), 64'd1);
            checkOutput("BIC held inReady", 64'(inReady0), 64'd0);
        end
        inValid0 = 1'b0;
        consume();
        @(negedge clk);
        checkOutput("BIC drained outValid", 64'(outValid0), 64'd0);
        checkOutput("BIC drained inReady", 64'(inReady0), 64'd1);
        checkOutput("BIC drained result", 64'(result0), 64'h0000_00F0);

        // Reset in the middle of a multiply aborts it
        applyStimulus(0, ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "MUL abort");
        repeat (9) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("abort outValid", 64'(outValid0), 64'd0);
        checkOutput("abort inReady", 64'(inReady0), 64'd1);
        checkOutput("abort result", 64'(result0), 64'd0);
        checkOutput("abort zero", 64'(zero0), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (outValid0) break;
        end
        checkOutput("abort no late result", 64'(outValid0), 64'd0);
        runOp(0, ALU_ADD, 32'd1, 32'd1, 32'd2, 4'b0000, 1, "ADD after reset");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    // Guard against a hung simulation.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/arm_cortex_m0_seq_alu.md
Name: arm_cortex_m0_seq_alu

Overview:
- Parametrised, handshaked successor to the combinational Cortex-M0 datapath ALU.
- Adds a registered result, full NZCV flags, BIC, and an iterative shift-add MULS. The multiply takes WIDTH cycles, or fewer when early termination is enabled.
- Sits between the decode/issue stage and writeback. The issue stage holds operands until accepted; writeback consumes the result via valid/ready.

Parameters:
- WIDTH, 32, datapath width in bits (>= 4).
- EARLY_TERM, 0, when 1 the multiply completes as soon as the remaining multiplier bits are zero.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- in_valid  in  1  operands/op presented.
- in_ready  out  1  block can accept an op.
- operand_A  in  WIDTH  first operand.
- operand_B  in  WIDTH  second operand.
- alu_control  in  3  opcode: 000 AND, 001 EOR, 010 SUB, 011 ADD, 100 ORR, 101 BIC (A & ~B), 110 MUL, 111 PASS_B.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  writeback consumes result.
- result  out  WIDTH  registered result.
- neg  out  1  N flag = result[WIDTH-1].
- zero  out  1  Z flag = (result == 0).
- carry  out  1  C flag.
- overflow  out  1  V flag.

Behaviour:
- Reset (async, active-high):
  - state=IDLE, in_ready=1, out_valid=0.
  - result, carry, overflow = 0; neg=0; zero=1 (derived from result=0).
  - Reset asserted mid-multiply aborts the op; no result is produced.
- FSM states: IDLE, MUL_BUSY, DONE.
  - in_ready = (state==IDLE). out_valid = (state==DONE).
- IDLE, accept (in_valid && in_ready) of a non-MUL op:
  - result and flags are computed and registered at that edge; state goes to DONE.
  - Latency is 1: out_valid is high the cycle after acceptance.
- IDLE, accept of MUL:
  - Load acc=0, mcand=operand_A, mplier=operand_B, count=0; state goes to MUL_BUSY.
- MUL_BUSY, each cycle:
  - if mplier[0], acc = acc + mcand (mod 2^WIDTH); then mcand <<= 1, mplier >>= 1, count++.
  - Leave to DONE (result <= acc) when count reaches WIDTH-1 at that edge.
  - With EARLY_TERM=1, also leave when the shifted mplier is zero.
  - Result is the low WIDTH bits of A*B (MULS semantics); signed and unsigned give identical low bits.
- MUL latency:
  - EARLY_TERM=0: out_valid exactly WIDTH+1 cycles after acceptance.
  - EARLY_TERM=1: 1 + max(1, index of highest set bit of B + 1) cycles.
  - B=0 completes after one busy cycle.
- DONE:
  - result and flags are held stable while out_valid && !out_ready.
  - When out_ready is high, go to IDLE at that edge.
  - Sustained throughput for single-cycle ops is one result per 2 cycles.
- Inputs are ignored when in_ready=0; operands need not be held after acceptance.
- Flags:
  - ADD: carry = carry-out of the WIDTH-bit sum; overflow = (A[msb]==B[msb]) && (R[msb]!=A[msb]).
  - SUB: computed as A + ~B + 1. carry = NOT borrow (1 when A >= B unsigned); overflow = (A[msb]!=B[msb]) && (R[msb]!=A[msb]).
  - AND/EOR/ORR/BIC/PASS_B/MUL: carry=0, overflow=0.
- Widths: the adder is WIDTH+1 bits internally; the MSB of the sum is the carry. count is $clog2(WIDTH) bits.

Decomposition:
- Shared package arm_m0_alu_pkg:
  - opcode localparams ALU_AND..ALU_PASS_B;
  - FSM state encoding (IDLE=2'd0, MUL_BUSY=2'd1, DONE=2'd2).
- One natural sub-module, arm_m0_iter_mul, holding:
  - acc/mcand/mplier/count registers;
  - start/done handshake with the FSM;
  - parametrised WIDTH and EARLY_TERM.
- Single-cycle ops and the flag logic stay in the top level.

Test Plan:
- Reset: assert reset mid-MUL (cycle 10) -> out_valid=0, in_ready=1, result=0, zero=1 asynchronously. The next ADD 1+1 gives result=2.
- ADD overflow: A=0x7FFFFFFF, B=1 -> result=0x80000000, N=1, Z=0, C=0, V=1, out_valid one cycle after acceptance.
- SUB edge cases:
  - A=5, B=5 -> result=0, Z=1, C=1, V=0.
  - A=0, B=1 -> result=0xFFFFFFFF, N=1, C=0.
- MUL timing, EARLY_TERM=0: A=0xFFFFFFFF, B=0xFFFFFFFF -> result=0x00000001, out_valid exactly 33 cycles after acceptance, in_ready=0 throughout.
- MUL early exit, EARLY_TERM=1: A=1234, B=3 -> result=3702 with latency 3. B=0 -> result=0, Z=1, latency 2.
- Backpressure: hold out_ready=0 for 5 cycles after a BIC with A=0xFF, B=0x0F -> result=0xF0 stable, in_ready=0, second in_valid ignored. out_ready=1 -> IDLE next cycle.
